debounce_tick: RTL and testbench
================================

DEBOUNCE_TICK -- requirements
Module: debounce_tick

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000; required stable-input time in clk cycles; legal range >= 2.
REQ-002 SHALL have parameter CNT_W, default 20; settle-counter width; legal only when 2**CNT_W > DB_CYCLES-1.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port sw  input  1  raw, asynchronous, bouncing mechanical input.
REQ-006 SHALL have port syn_clr  input  1  synchronous clear of the debounce FSM.
REQ-007 SHALL have port db_level  output  1  debounced level of sw.
REQ-008 SHALL have port db_tick  output  1  one-cycle pulse on each debounced 0->1 edge; drives a downstream counter enable.
REQ-009 SHALL have port db_fall_tick  output  1  one-cycle pulse on each debounced 1->0 edge.
REQ-010 SHALL have port busy  output  1  high while a transition is being qualified.

Function
REQ-011 SHALL pass sw through a two-flop synchronizer (s1, then sync_in); the FSM SHALL use only sync_in.
REQ-012 SHALL implement four states: ZERO, WAIT1, ONE, WAIT0, with a down-counter cnt[CNT_W-1:0].
REQ-013 ZERO: sync_in=1 -> WAIT1 with cnt loaded to DB_CYCLES-1; otherwise hold.
REQ-014 WAIT1: sync_in=0 -> ZERO (bounce abort, no pulse); else cnt=0 -> ONE; else cnt decrements by 1.
REQ-015 ONE: sync_in=0 -> WAIT0 with cnt loaded to DB_CYCLES-1; otherwise hold.
REQ-016 WAIT0: sync_in=1 -> ONE (abort, no pulse); else cnt=0 -> ZERO; else cnt decrements by 1.
REQ-017 Each WAIT state SHALL therefore last exactly DB_CYCLES cycles when the input stays stable.
REQ-018 db_level SHALL be 1 in states ONE and WAIT0 and 0 in ZERO and WAIT1; busy SHALL be 1 in WAIT1 and WAIT0 only.
REQ-019 db_tick SHALL be a registered output, high for exactly the first cycle after a WAIT1->ONE transition, coincident with db_level rising.
REQ-020 db_fall_tick SHALL be a registered output, high for exactly the first cycle after a WAIT0->ZERO transition, coincident with db_level falling.
REQ-021 db_tick and db_fall_tick SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-022 Latency: with sw stable 1 before edge E0 and FSM in ZERO, db_level and db_tick SHALL be 1 after edge E(DB_CYCLES+2); the falling edge SHALL be symmetric.
REQ-023 cnt SHALL never wrap; the decrement SHALL occur only when cnt != 0.
REQ-024 syn_clr=1 SHALL force, at the next edge, state ZERO, cnt=0, db_tick=0 and db_fall_tick=0, with priority over all FSM transitions; the synchronizer SHALL be unaffected.
REQ-025 After syn_clr deasserts with sync_in=1, the FSM SHALL requalify from ZERO (full DB_CYCLES wait) before db_tick is raised.
REQ-026 Aborts (REQ-014, REQ-016) SHALL not generate any pulse and SHALL leave db_level unchanged.

Reset
REQ-027 rst_n=0 SHALL immediately clear s1, sync_in, cnt, db_tick and db_fall_tick to 0 and put the state in ZERO (db_level=0, busy=0), independent of clk.
REQ-028 Reset asserted mid-qualification SHALL discard the qualification, and no pulse SHALL be emitted on or after deassertion until a new full qualification completes.
REQ-029 After rst_n deasserts with sw=1, db_tick SHALL first assert DB_CYCLES+2 edges after sync_in can first capture a 1.

Verification (DB_CYCLES=4, CNT_W=3)
REQ-030 sw 0->1 held before E0 -> busy=1 after E2; db_level=1 and db_tick=1 after E6 only; db_tick=0 after E7.
REQ-031 sw high for 3 cycles, then low (bounce) -> busy pulses, then returns to ZERO; db_level stays 0; db_tick never asserted.
REQ-032 From ONE, sw 1->0 held -> db_fall_tick=1 for one cycle, coincident with db_level=0, 6 edges after the change is sampled.
REQ-033 syn_clr=1 for one cycle during WAIT1 with sw held 1 -> ZERO at the next edge; db_tick asserts 5 edges after syn_clr deasserts (1 edge back to WAIT1, then 4 in WAIT1).
REQ-034 rst_n pulsed low asynchronously (between edges) while in WAIT0 -> all outputs 0 immediately; no db_fall_tick is emitted.
REQ-035 sw driven by 10 successive 1-cycle glitches -> db_level, db_tick and db_fall_tick all remain 0 throughout.

Source files
------------

// File: rtl/debounce_tick.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_tick
//  Description : Mechanical-switch debouncer. Two-flop synchronizer feeding a
//                four-state qualify FSM with a settle down-counter; emits the
//                debounced level, registered rise/fall ticks and a busy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_tick #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    input  logic syn_clr,
    output logic db_level,
    output logic db_tick,
    output logic db_fall_tick,
    output logic busy
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    // Loading DB_CYCLES-1 and counting down to zero inclusive makes each
    // wait state last exactly DB_CYCLES cycles on a stable input.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             sync_in;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    // Two-flop synchronizer for the raw switch; syn_clr deliberately leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= 1'b0;
            sync_in <= 1'b0;
        end else begin
            s1      <= sw;
            sync_in <= s1;
        end
    end

    // FSM state, settle counter and registered edge ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ZERO;
            cnt          <= '0;
            db_tick      <= 1'b0;
            db_fall_tick <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            db_tick      <= rise_nxt;
            db_fall_tick <= fall_nxt;
        end
    end

    // Next-state, counter and tick decode; syn_clr overrides every transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            ZERO: begin
                if (sync_in) begin
                    state_nxt = WAIT1;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sync_in) begin
                    state_nxt = ZERO;
                end else if (cnt == '0) begin
                    state_nxt = ONE;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ONE: begin
                if (!sync_in) begin
                    state_nxt = WAIT0;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sync_in) begin
                    state_nxt = ONE;
                end else if (cnt == '0) begin
                    state_nxt = ZERO;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ZERO;
                cnt_nxt   = '0;
            end
        endcase
        if (syn_clr) begin
            state_nxt = ZERO;
            cnt_nxt   = '0;
            rise_nxt  = 1'b0;
            fall_nxt  = 1'b0;
        end
    end

    // Level and busy are pure functions of the state.
    always_comb begin
        db_level = (state == ONE) || (state == WAIT0);
        busy     = (state == WAIT1) || (state == WAIT0);
    end

endmodule
`default_nettype wire

// File: tb/tb_debounce_tick.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_tick
//  Description : Self-checking bench for debounce_tick (DB_CYCLES=4, CNT_W=3).
//                A run-length model predicts outputs every cycle; directed
//                sequences pin exact edge latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_tick;

    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sw;
    logic syn_clr;
    logic db_level;
    logic db_tick;
    logic db_fall_tick;
    logic busy;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    debounce_tick #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .syn_clr      (syn_clr),
        .db_level     (db_level),
        .db_tick      (db_tick),
        .db_fall_tick (db_fall_tick),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Model: the debounced level flips once the synchronized input has
    // disagreed with it on DB+1 consecutive sampling edges; any agreeing
    // sample restarts the run. busy means a run is in progress.
    logic m_s1, m_sync, m_level, m_rise, m_fall;
    int   m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= 0; m_sync <= 0; m_level <= 0; m_rise <= 0; m_fall <= 0; m_run <= 0;
        end else begin
            m_s1   <= sw;
            m_sync <= m_s1;
            m_rise <= 0;
            m_fall <= 0;
            if (syn_clr) begin
                m_level <= 0;
                m_run   <= 0;
            end else if (m_sync == m_level) begin
                m_run <= 0;
            end else if (m_run == DB) begin
                m_level <= ~m_level;
                m_run   <= 0;
                m_rise  <= ~m_level;
                m_fall  <= m_level;
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("model_level", {31'd0, db_level}, {31'd0, m_level});
            chk("model_tick", {31'd0, db_tick}, {31'd0, m_rise});
            chk("model_fall", {31'd0, db_fall_tick}, {31'd0, m_fall});
            chk("model_busy", {31'd0, busy}, {31'd0, (m_run != 0)});
            chk("ticks_exclusive", {31'd0, db_tick & db_fall_tick}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b1; sw = 1'b0; syn_clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_level", {31'd0, db_level}, 32'd0);
        chk("reset_tick", {31'd0, db_tick}, 32'd0);
        chk("reset_fall", {31'd0, db_fall_tick}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        step_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step_cycles(2);

        // Rising qualification: busy after E2, level+tick after E6, tick gone after E7.
        @(negedge clk); sw = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 2) chk("rise_busy_E2", {31'd0, busy}, 32'd1);
            if (k == 5) chk("rise_level_E5", {31'd0, db_level}, 32'd0);
            if (k == 6) begin
                chk("rise_level_E6", {31'd0, db_level}, 32'd1);
                chk("rise_tick_E6", {31'd0, db_tick}, 32'd1);
            end
            if (k == 7) chk("rise_tick_E7", {31'd0, db_tick}, 32'd0);
        end
        step_cycles(3);

        // Falling qualification, symmetric latency.
        @(negedge clk); sw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (k == 5) chk("fall_level_E5", {31'd0, db_level}, 32'd1);
            if (k == 6) begin
                chk("fall_level_E6", {31'd0, db_level}, 32'd0);
                chk("fall_tick_E6", {31'd0, db_fall_tick}, 32'd1);
            end
            if (k == 7) chk("fall_tick_E7", {31'd0, db_fall_tick}, 32'd0);
        end

        // Bounce: three cycles high, then low; must abort with no pulse.
        @(negedge clk); sw = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin @(negedge clk); sw = 1'b0; end
            @(posedge clk); #1;
            seen = seen | db_level | db_tick;
        end
        chk("bounce_no_rise", {31'd0, seen}, 32'd0);
        chk("bounce_idle", {31'd0, busy}, 32'd0);

        // syn_clr in WAIT1: back to ZERO, then a full requalification.
        @(negedge clk); sw = 1'b1;
        step_cycles(4);
        @(negedge clk); syn_clr = 1'b1;
        @(posedge clk); #1;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); syn_clr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("clr_rewait", {31'd0, busy}, 32'd1);
            if (k == 4) chk("clr_tick_early", {31'd0, db_tick}, 32'd0);
            if (k == 5) chk("clr_tick", {31'd0, db_tick}, 32'd1);
        end
        step_cycles(2);

        // Asynchronous reset during WAIT0: outputs clear at once, no fall tick later.
        @(negedge clk); sw = 1'b0;
        step_cycles(4);
        #3;
        chk("wait0_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_level", {31'd0, db_level}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_fall", {31'd0, db_fall_tick}, 32'd0);
        #7 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            seen = seen | db_fall_tick | db_tick;
        end
        chk("arst_no_pulse", {31'd0, seen}, 32'd0);

        // Ten single-cycle glitches: nothing may qualify.
        seen = 1'b0;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk); sw = 1'b1;
            @(posedge clk); #1; seen = seen | db_level | db_tick | db_fall_tick;
            @(negedge clk); sw = 1'b0;
            @(posedge clk); #1; seen = seen | db_level | db_tick | db_fall_tick;
        end
        step_cycles(4);
        chk("glitch_quiet", {31'd0, seen}, 32'd0);

        // Reset released with sw already high: qualification runs from scratch.
        @(negedge clk); rst_n = 1'b0; sw = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        step_cycles(10);
        #1;
        chk("post_reset_level", {31'd0, db_level}, 32'd1);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
